// File: rtl/debug_sequencer.sv
// +--------------------------------------------------------------------------+
// | debug_sequencer : run/step/freeze control and PC + register dump to UART |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module debug_sequencer #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int N_REGS      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  input  logic                   i_program_end,
  input  logic [NB_DATA-1:0]     i_pc,
  output logic [NB_REG_ADDR-1:0] o_r_addr,
  input  logic [NB_DATA-1:0]     i_r_data,
  output logic                   o_halt,
  output logic                   o_busy
);

  localparam int NB_IDX = $clog2(N_REGS + 1);

  localparam logic [7:0]        c_cmd_cont  = 8'h43;
  localparam logic [7:0]        c_cmd_step  = 8'h53;
  localparam logic [7:0]        c_cmd_read  = 8'h52;
  localparam logic [1:0]        c_last_byte = 2'd3;
  localparam logic [NB_IDX-1:0] c_last_word = NB_IDX'(N_REGS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP      = 3'd2,
    ST_LOAD      = 3'd3,
    ST_SEND      = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [NB_IDX-1:0]   r_word_idx;
  logic [1:0]          r_byte_cnt;
  logic [NB_DATA-1:0]  r_shift_reg;
  logic [7:0]          r_tx_data;
  logic [NB_DATA-1:0]  w_load_word;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == c_cmd_cont)
            w_next_state = i_program_end ? ST_LOAD : ST_RUN;
          else if (i_rx_data == c_cmd_step)
            w_next_state = ST_STEP;
          else if (i_rx_data == c_cmd_read)
            w_next_state = ST_LOAD;
        end
      end
      ST_RUN:  if (i_program_end) w_next_state = ST_LOAD;
      ST_STEP: w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_SEND;
      ST_SEND: w_next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          if (r_byte_cnt != c_last_byte)    w_next_state = ST_SEND;
          else if (r_word_idx < c_last_word) w_next_state = ST_LOAD;
          else                               w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Word 0 of the frame is the PC; word k>0 is register k-1.
  assign w_load_word = (r_word_idx == '0) ? i_pc : i_r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word_idx  <= '0;
      r_byte_cnt  <= '0;
      r_shift_reg <= '0;
      r_tx_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN, ST_STEP: begin
          if (w_next_state == ST_LOAD) begin
            r_word_idx <= '0;
            r_byte_cnt <= '0;
          end
        end
        ST_LOAD: begin
          r_shift_reg <= w_load_word;
          r_byte_cnt  <= '0;
          r_tx_data   <= w_load_word[NB_DATA-1 -: 8];
        end
        ST_WAIT_DONE: begin
          if (i_tx_done) begin
            if (r_byte_cnt != c_last_byte) begin
              r_shift_reg <= r_shift_reg << 8;
              r_byte_cnt  <= r_byte_cnt + 2'd1;
              r_tx_data   <= r_shift_reg[NB_DATA-9 -: 8];
            end else if (r_word_idx < c_last_word) begin
              r_word_idx <= r_word_idx + NB_IDX'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // r_tx_data is preloaded with the byte SEND will present, so it equals
  // shift_reg[MSB] during SEND and simply holds at all other times.
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = (r_state == ST_SEND);
  assign o_r_addr   = (r_word_idx == '0) ? '0
                      : NB_REG_ADDR'(r_word_idx - NB_IDX'(1));
  assign o_halt     = !((r_state == ST_RUN) || (r_state == ST_STEP));
  assign o_busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire
